// File: rtl/mem_arbiter.sv
// Two-port arbiter for the core's unified instruction/data memory.
// Serialises core and debug/boot-loader requests, alternating fairly under contention.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LAT    = 2
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_ack,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,

    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,

    output logic              busy,
    output logic              owner
);

    localparam int unsigned     CW       = $clog2(LAT + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt, cnt_nxt, cnt_inc;
    logic                last_grant;
    logic                owner_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                grant_vld;
    logic                grant_sel;
    logic                take;

    // Under contention the side that did not win last time gets the slot.
    always_comb begin
        grant_vld = c_req | d_req;
        grant_sel = (c_req & d_req) ? ~last_grant : d_req;
        take      = (state == IDLE) & grant_vld;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cnt_inc   = cnt + CW'(1);
        case (state)
            IDLE: begin
                if (grant_vld)
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                cnt_nxt   = '0;
                state_nxt = (LAT == 1) ? DONE : WAIT;
            end
            WAIT: begin
                cnt_nxt = cnt_inc;
                if (cnt_inc == CNT_LAST)
                    state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (take) begin
                last_grant <= grant_sel;
                owner_q    <= grant_sel;
                we_q       <= grant_sel ? d_we    : c_we;
                addr_q     <= grant_sel ? d_addr  : c_addr;
                wdata_q    <= grant_sel ? d_wdata : c_wdata;
            end
        end
    end

    // Write completions return zero read data to the owner.
    always_comb begin
        m_en    = (state == ISSUE);
        m_we    = (state == ISSUE) & we_q;
        m_addr  = addr_q;
        m_wdata = wdata_q;
        busy    = (state != IDLE);
        owner   = owner_q;
        c_ack   = (state == DONE) & ~owner_q;
        d_ack   = (state == DONE) &  owner_q;
        c_rdata = (c_ack & ~we_q) ? m_rdata : '0;
        d_rdata = (d_ack & ~we_q) ? m_rdata : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cycle table, LAT=1 sequence, and random
// traffic checked against a transaction-timeline model.
module tb_mem_arbiter;

    localparam int unsigned LAT0  = 2;
    localparam int          NRAND = 3000;
    localparam logic [31:0] GARB  = 32'hBADBAD00;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        c_req = 0, c_we = 0, d_req = 0, d_we = 0;
    logic [31:0] c_addr = 0, c_wdata = 0, d_addr = 0, d_wdata = 0;
    logic [31:0] c_rdata, d_rdata, m_addr, m_wdata, m_rdata;
    logic        c_ack, d_ack, m_en, m_we, busy, owner;

    logic        use_tbl = 1'b1;
    logic [31:0] tbl_rdata = GARB;
    logic [31:0] mem_rdata;
    assign m_rdata = use_tbl ? tbl_rdata : mem_rdata;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(LAT0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_ack(c_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .busy(busy), .owner(owner)
    );

    logic        l_c_req = 0, l_c_we = 0, l_d_req = 0, l_d_we = 0;
    logic [31:0] l_c_addr = 0, l_c_wdata = 0, l_d_addr = 0, l_d_wdata = 0;
    logic [31:0] l_c_rdata, l_d_rdata, l_m_addr, l_m_wdata;
    logic [31:0] l_m_rdata = GARB;
    logic        l_c_ack, l_d_ack, l_m_en, l_m_we, l_busy, l_owner;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .c_req(l_c_req), .c_we(l_c_we), .c_addr(l_c_addr), .c_wdata(l_c_wdata),
        .c_rdata(l_c_rdata), .c_ack(l_c_ack),
        .d_req(l_d_req), .d_we(l_d_we), .d_addr(l_d_addr), .d_wdata(l_d_wdata),
        .d_rdata(l_d_rdata), .d_ack(l_d_ack),
        .m_en(l_m_en), .m_we(l_m_we), .m_addr(l_m_addr), .m_wdata(l_m_wdata),
        .m_rdata(l_m_rdata), .busy(l_busy), .owner(l_owner)
    );

    // Environment memory: data appears LAT0 cycles after the m_en cycle, garbage otherwise.
    logic [31:0]       mem [logic [31:0]];
    logic [LAT0-1:0]   en_pipe = '0;
    logic [31:0]       rd_pipe [LAT0];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a * 32'h9E3779B1 + 32'h1234;
    endfunction

    always @(posedge clk) begin
        en_pipe <= {en_pipe[LAT0-2:0], m_en};
        for (int i = LAT0 - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        rd_pipe[0] <= mem_rd(m_addr);
        if (m_en && m_we) mem[m_addr] = m_wdata;
    end
    assign mem_rdata = en_pipe[LAT0-1] ? rd_pipe[LAT0-1] : GARB;

    int nchk = 0;
    int npass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    typedef struct {
        logic        rst, creq, cwe;
        logic [31:0] caddr, cwdata;
        logic        dreq, dwe;
        logic [31:0] daddr, dwdata, mrd;
        logic        men, mwe;
        logic [31:0] maddr, mwdata;
        logic        cack;
        logic [31:0] crd;
        logic        dack;
        logic [31:0] drd;
        logic        busy, own;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(
        input logic rst, creq, cwe, input logic [31:0] caddr, cwdata,
        input logic dreq, dwe, input logic [31:0] daddr, dwdata, mrd,
        input logic men, mwe, input logic [31:0] maddr, mwdata,
        input logic cack, input logic [31:0] crd, input logic dack, input logic [31:0] drd,
        input logic bsy, own);
        vec_t v;
        v.rst = rst; v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwdata = cwdata;
        v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwdata = dwdata; v.mrd = mrd;
        v.men = men; v.mwe = mwe; v.maddr = maddr; v.mwdata = mwdata;
        v.cack = cack; v.crd = crd; v.dack = dack; v.drd = drd; v.busy = bsy; v.own = own;
        tbl.push_back(v);
    endfunction

    // Timeline model for random traffic.
    int          mo_issue, mo_done;
    logic        mo_who, mo_we, mo_last, mo_owner;
    logic [31:0] mo_addr, mo_wdata;

    task automatic next_req(input logic me, input int n, input logic cur, output logic nreq);
        if (mo_done == n - 1 && mo_who == me) nreq = ($urandom_range(0, 2) == 0);
        else if (!cur) nreq = ($urandom_range(0, 2) == 0);
        else if (mo_who == me && n >= mo_issue && n < mo_done && $urandom_range(0, 9) == 0) nreq = 1'b0;
        else nreq = cur;
    endtask

    initial begin
        logic [31:0] a, dat;
        logic        who, g;
        logic [31:0] e_crd, e_drd;

        // ---------------- directed table, LAT=2 ----------------
        add(0,1,0,'h100,0, 1,0,'h200,0, GARB, 0,0,0,0, 0,0,0,0, 0,0);
        add(0,1,0,'h100,0, 1,0,'h200,0, GARB, 0,0,0,0, 0,0,0,0, 0,0);
        add(1,1,0,'h100,0, 0,0,0,0, GARB, 0,0,0,0, 0,0,0,0, 0,0);
        add(1,1,0,'h100,0, 0,0,0,0, GARB, 1,0,'h100,0, 0,0,0,0, 1,0);
        add(1,1,0,'h100,0, 0,0,0,0, GARB, 0,0,'h100,0, 0,0,0,0, 1,0);
        add(1,1,0,'h100,0, 0,0,0,0, 'hDEADBEEF, 0,0,'h100,0, 1,'hDEADBEEF,0,0, 1,0);
        add(1,0,0,'h100,0, 0,0,0,0, GARB, 0,0,'h100,0, 0,0,0,0, 0,0);
        add(1,0,0,0,0, 1,1,'h200,'h12345678, GARB, 0,0,'h100,0, 0,0,0,0, 0,0);
        add(1,0,0,0,0, 1,1,'h999,'hFFFF0000, GARB, 1,1,'h200,'h12345678, 0,0,0,0, 1,1);
        add(1,0,0,0,0, 1,1,'h999,'hFFFF0000, GARB, 0,0,'h200,'h12345678, 0,0,0,0, 1,1);
        add(1,0,0,0,0, 1,0,'h999,'hFFFF0000, 'hCAFEF00D, 0,0,'h200,'h12345678, 0,0,1,0, 1,1);
        add(1,0,0,0,0, 0,0,0,0, GARB, 0,0,'h200,'h12345678, 0,0,0,0, 0,1);
        // contention from reset: core, debug, core, debug
        add(0,1,0,'h10,0, 1,0,'h20,0, GARB, 0,0,0,0, 0,0,0,0, 0,0);
        add(0,1,0,'h10,0, 1,0,'h20,0, GARB, 0,0,0,0, 0,0,0,0, 0,0);
        add(1,1,0,'h10,0, 1,0,'h20,0, GARB, 0,0,0,0, 0,0,0,0, 0,0);
        for (int k = 0; k < 4; k++) begin
            who = k[0];
            a   = who ? 32'h20 : 32'h10;
            dat = 32'h11111111 * (k + 1);
            add(1,1,0,'h10,0, 1,0,'h20,0, GARB, 1,0,a,0, 0,0,0,0, 1,who);
            add(1,1,0,'h10,0, 1,0,'h20,0, GARB, 0,0,a,0, 0,0,0,0, 1,who);
            add(1,1,0,'h10,0, 1,0,'h20,0, dat,  0,0,a,0, !who, who ? 32'h0 : dat, who, who ? dat : 32'h0, 1,who);
            add(1,k<3,0,'h10,0, k<3,0,'h20,0, GARB, 0,0,a,0, 0,0,0,0, 0,who);
        end
        // reset in the middle of a core read, then contention restarts with core first
        add(1,1,0,'h300,0, 0,0,0,0, GARB, 0,0,'h20,0, 0,0,0,0, 0,1);
        add(1,1,0,'h300,0, 0,0,0,0, GARB, 1,0,'h300,0, 0,0,0,0, 1,0);
        add(0,0,0,'h300,0, 0,0,0,0, GARB, 0,0,0,0, 0,0,0,0, 0,0);
        add(0,0,0,'h300,0, 0,0,0,0, 'h77777777, 0,0,0,0, 0,0,0,0, 0,0);
        add(1,0,0,'h300,0, 0,0,0,0, 'h77777777, 0,0,0,0, 0,0,0,0, 0,0);
        add(1,1,0,'h300,0, 1,0,'h400,0, GARB, 0,0,0,0, 0,0,0,0, 0,0);
        add(1,1,0,'h300,0, 1,0,'h400,0, GARB, 1,0,'h300,0, 0,0,0,0, 1,0);
        add(1,1,0,'h300,0, 1,0,'h400,0, GARB, 0,0,'h300,0, 0,0,0,0, 1,0);
        add(1,1,0,'h300,0, 1,0,'h400,0, 'h55555555, 0,0,'h300,0, 1,'h55555555,0,0, 1,0);
        add(1,0,0,0,0, 0,0,0,0, GARB, 0,0,'h300,0, 0,0,0,0, 0,0);

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            rst_n = tbl[i].rst;
            c_req = tbl[i].creq; c_we = tbl[i].cwe; c_addr = tbl[i].caddr; c_wdata = tbl[i].cwdata;
            d_req = tbl[i].dreq; d_we = tbl[i].dwe; d_addr = tbl[i].daddr; d_wdata = tbl[i].dwdata;
            tbl_rdata = tbl[i].mrd;
            @(negedge clk);
            chk($sformatf("row%0d m_en", i),    {31'b0, m_en},  {31'b0, tbl[i].men});
            if (tbl[i].men || !tbl[i].rst)
                chk($sformatf("row%0d m_we", i), {31'b0, m_we}, {31'b0, tbl[i].mwe});
            chk($sformatf("row%0d m_addr", i),  m_addr,  tbl[i].maddr);
            chk($sformatf("row%0d m_wdata", i), m_wdata, tbl[i].mwdata);
            chk($sformatf("row%0d c_ack", i),   {31'b0, c_ack}, {31'b0, tbl[i].cack});
            chk($sformatf("row%0d c_rdata", i), c_rdata, tbl[i].crd);
            chk($sformatf("row%0d d_ack", i),   {31'b0, d_ack}, {31'b0, tbl[i].dack});
            chk($sformatf("row%0d d_rdata", i), d_rdata, tbl[i].drd);
            chk($sformatf("row%0d busy", i),    {31'b0, busy},  {31'b0, tbl[i].busy});
            chk($sformatf("row%0d owner", i),   {31'b0, owner}, {31'b0, tbl[i].own});
        end

        // ---------------- LAT=1 instance: read then back-to-back write ----------------
        @(posedge clk); #1; l_c_req = 1; l_c_we = 0; l_c_addr = 32'h40;
        @(negedge clk);
        chk("l1 idle busy", {31'b0, l_busy}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("l1 issue m_en", {31'b0, l_m_en}, 32'h1);
        chk("l1 issue m_addr", l_m_addr, 32'h40);
        chk("l1 issue c_ack", {31'b0, l_c_ack}, 32'h0);
        @(posedge clk); #1; l_m_rdata = 32'hA5A5A5A5;
        @(negedge clk);
        chk("l1 done c_ack", {31'b0, l_c_ack}, 32'h1);
        chk("l1 done c_rdata", l_c_rdata, 32'hA5A5A5A5);
        chk("l1 done busy", {31'b0, l_busy}, 32'h1);
        chk("l1 done d_ack", {31'b0, l_d_ack}, 32'h0);
        chk("l1 done d_rdata", l_d_rdata, 32'h0);
        @(posedge clk); #1; l_m_rdata = GARB; l_c_we = 1; l_c_addr = 32'h44; l_c_wdata = 32'h77;
        @(negedge clk);
        chk("l1 post busy", {31'b0, l_busy}, 32'h0);
        chk("l1 post c_ack", {31'b0, l_c_ack}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("l1 wr m_en", {31'b0, l_m_en}, 32'h1);
        chk("l1 wr m_we", {31'b0, l_m_we}, 32'h1);
        chk("l1 wr m_wdata", l_m_wdata, 32'h77);
        chk("l1 wr owner", {31'b0, l_owner}, 32'h0);
        @(posedge clk); #1; l_m_rdata = 32'h12121212;
        @(negedge clk);
        chk("l1 wr c_ack", {31'b0, l_c_ack}, 32'h1);
        chk("l1 wr c_rdata", l_c_rdata, 32'h0);
        @(posedge clk); #1; l_c_req = 0;
        @(negedge clk);
        chk("l1 end busy", {31'b0, l_busy}, 32'h0);

        // ---------------- random traffic vs timeline model ----------------
        @(posedge clk); #1;
        rst_n = 0; c_req = 0; d_req = 0; use_tbl = 0;
        @(posedge clk); #1;
        rst_n = 1;
        mo_issue = -100; mo_done = -100; mo_who = 0; mo_we = 0;
        mo_last = 1; mo_owner = 0; mo_addr = 0; mo_wdata = 0;

        for (int n = 0; n < NRAND; n++) begin
            @(posedge clk); #1;
            next_req(1'b0, n, c_req, c_req);
            next_req(1'b1, n, d_req, d_req);
            c_we = 1'($urandom); c_addr = {26'b0, 4'($urandom_range(0, 15)), 2'b00}; c_wdata = $urandom;
            d_we = 1'($urandom); d_addr = {26'b0, 4'($urandom_range(0, 15)), 2'b00}; d_wdata = $urandom;
            @(negedge clk);
            e_crd = (n == mo_done && !mo_who && !mo_we) ? mem_rd(mo_addr) : 32'h0;
            e_drd = (n == mo_done &&  mo_who && !mo_we) ? mem_rd(mo_addr) : 32'h0;
            chk($sformatf("rnd%0d m_en", n), {31'b0, m_en}, {31'b0, n == mo_issue});
            if (n == mo_issue) chk($sformatf("rnd%0d m_we", n), {31'b0, m_we}, {31'b0, mo_we});
            chk($sformatf("rnd%0d m_addr", n), m_addr, mo_addr);
            chk($sformatf("rnd%0d m_wdata", n), m_wdata, mo_wdata);
            chk($sformatf("rnd%0d busy", n), {31'b0, busy}, {31'b0, n >= mo_issue && n <= mo_done});
            chk($sformatf("rnd%0d owner", n), {31'b0, owner}, {31'b0, mo_owner});
            chk($sformatf("rnd%0d c_ack", n), {31'b0, c_ack}, {31'b0, n == mo_done && !mo_who});
            chk($sformatf("rnd%0d d_ack", n), {31'b0, d_ack}, {31'b0, n == mo_done && mo_who});
            chk($sformatf("rnd%0d c_rdata", n), c_rdata, e_crd);
            chk($sformatf("rnd%0d d_rdata", n), d_rdata, e_drd);
            if (n > mo_done && (c_req || d_req)) begin
                g         = (c_req && d_req) ? !mo_last : d_req;
                mo_last   = g;
                mo_owner  = g;
                mo_who    = g;
                mo_we     = g ? d_we    : c_we;
                mo_addr   = g ? d_addr  : c_addr;
                mo_wdata  = g ? d_wdata : c_wdata;
                mo_issue  = n + 1;
                mo_done   = n + 1 + int'(LAT0);
            end
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single unified instruction/data memory of the multicycle core between two requesters: the core's memory port (fetch, load, store) and the debug/boot-loader port.
- Each requester runs a req/ack handshake. The block sequences one memory transaction at a time with a fixed, parameterised memory latency and alternates fairly when both requesters contend.
- The core FSM stalls on its memory states until c_ack arrives.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
LAT, 2, memory latency in cycles from the m_en cycle to the m_rdata-valid/write-complete cycle; legal range 1..8

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
c_req  in  1  core request; held high until c_ack
c_we  in  1  core write enable (1=store)
c_addr  in  ADDR_W  core address
c_wdata  in  DATA_W  core write data
c_rdata  out  DATA_W  core read data; valid only while c_ack=1
c_ack  out  1  core transaction complete, one-cycle pulse
d_req  in  1  debug request; held high until d_ack
d_we  in  1  debug write enable
d_addr  in  ADDR_W  debug address
d_wdata  in  DATA_W  debug write data
d_rdata  out  DATA_W  debug read data; valid only while d_ack=1
d_ack  out  1  debug transaction complete, one-cycle pulse
m_en  out  1  memory access strobe, one cycle per transaction
m_we  out  1  memory write enable, qualified by m_en
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_rdata  in  DATA_W  memory read data, valid LAT cycles after m_en
busy  out  1  transaction in flight (state != IDLE)
owner  out  1  current or last grant: 0=core, 1=debug

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE and the cycle counter clears.
  - All outputs are 0, including rdata buses and m_addr/m_wdata.
  - last_grant is set to debug, so the core wins the first contention.
- States:
  - IDLE: waiting for a request.
  - ISSUE: the one m_en cycle.
  - WAIT: counting latency.
  - DONE: ack cycle.
  - IDLE -> ISSUE: on the clock edge of a cycle with c_req|d_req = 1.
  - ISSUE -> WAIT when LAT>=2. ISSUE -> DONE when LAT=1.
  - WAIT -> DONE: when the counter reaches LAT-1.
  - DONE -> IDLE: always.
- Grant decision (IDLE cycle T, combinational):
  - Only one req high: that requester is granted.
  - Both high: the requester not equal to last_grant is granted.
  - At the edge ending T: the granted requester's we/addr/wdata are latched and owner/last_grant are updated.
- Cycle T+1 (ISSUE): m_en=1; m_we/m_addr/m_wdata come from the latched values.
- m_en=0 in every other state. m_addr/m_wdata hold their latched values until the next grant.
- DONE cycle is T+1+LAT:
  - The owner's ack is 1 for exactly this cycle.
  - Owner's rdata = m_rdata for reads; 0 for writes.
  - The non-owner's ack and rdata stay 0.
- Counter: clears in ISSUE and increments in WAIT. Width is $clog2(LAT+1); no wrap occurs because LAT<=8.
- Request inputs are ignored outside IDLE. Changes to we/addr/wdata after the grant have no effect on the transaction.
- Request dropped mid-transaction: the transaction still completes and the ack is still pulsed.
- Back-to-back requests:
  - A requester whose req is still high in the IDLE cycle after DONE is treated as a new request.
  - A requester must drop req on the edge at which it samples ack.
  - Minimum transaction spacing is LAT+2 cycles.
- Fairness: with both requesters continuously requesting, grants alternate core, debug, core, ... No starvation beyond one transaction.
- Reset mid-operation:
  - Outputs go to 0 immediately and asynchronously.
  - The in-flight transaction is abandoned and no ack is issued after release.
  - Arbitration restarts with core priority.
- busy = 1 in ISSUE/WAIT/DONE.

Test Plan:
- Reset: rst_n=0 with c_req=d_req=1 -> m_en, c_ack, d_ack, busy all 0 and rdata buses 0. After release, the first grant goes to core (owner=0).
- Core read, LAT=2: c_req=1, c_addr=0x100 at T -> T+1: m_en=1, m_we=0, m_addr=0x100. Memory drives 0xDEADBEEF at T+3 -> c_ack=1 and c_rdata=0xDEADBEEF at T+3 only; d_ack stays 0.
- Debug write: d_req=1, d_addr=0x200, d_wdata=0x12345678 -> one-cycle m_en=1, m_we=1, m_wdata=0x12345678 at T+1. d_ack=1 at T+3 with d_rdata=0. Fields are ignored after the grant: changing d_addr to 0x999 at T+1 leaves m_addr=0x200.
- Contention: both req held continuously from reset -> grant order is core, debug, core, debug. Acks land at T+3, T+7, T+11, T+15, with m_en at T+1, T+5, T+9, T+13.
- LAT=1 build: core read -> m_en at T+1, c_ack at T+2; the WAIT state is never entered.
- Reset mid-transaction: assert rst_n=0 at T+2 of a core read, release at T+4 -> no c_ack ever pulses. Simultaneous requests at T+5 grant core first.
